// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit constants and frame state encoding
// Contents:
//   uart_state_e          IDLE=0, START=1, DATA=2, STOP=3
//   DEFAULT_DELAY_FRAMES  clocks per bit for 27 MHz / 115200 baud
//   FRAME_BITS            data bits per 8N1 frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_DELAY_FRAMES = 234;
  localparam int FRAME_BITS           = 8;

endpackage

// File: rtl/uart_tx_serial.sv
// rtl/uart_tx_serial.sv - 8N1 serializer owning START/DATA/STOP bit timing
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   start_i  byte accepted this edge (honoured only while idle)
//   data_i   byte to transmit, latched on start_i
//   idle_o   serializer is in IDLE and can take a byte
//   busy_o   frame in progress (START, DATA or STOP)
//   tx_o     registered serial line, idles high
module uart_tx_serial
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       idle_o,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int                BAUD_W    = $clog2(DELAY_FRAMES);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DELAY_FRAMES - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(FRAME_BITS - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_done;

  assign baud_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shift_d = data_i;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The line is decoded from the next state so the pin flips on the same
    // edge as the state register while still coming straight from a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign idle_o = (state_q == IDLE);
  assign busy_o = (state_q != IDLE);
  assign tx_o   = tx_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one 8N1 UART transmit line
// Optional feature macro: UART_TX_PACKET_LOCK_EN (adds req_last, packet lock)
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   req_valid  per-requester byte available
//   req_data   byte of requester i on [8*i+7:8*i]
//   req_last   (lock build only) byte ends the requester's packet
//   req_ready  one-hot grant, only while the serializer is idle
//   uart_tx    serial line, idles high
//   busy       frame in progress
//   grant_id   index of the most recently granted requester
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
  parameter int NUM_REQ      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_TX_PACKET_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_last,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  logic [2:0]         rr_q, rr_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] eligible;
  logic [2:0]         win_id;
  logic [2:0]         next_ptr;
  logic               win_found;
  logic [7:0]         win_data;
  logic               ser_idle;
  logic               accept;
  int                 cand;

`ifdef UART_TX_PACKET_LOCK_EN
  logic       lock_q, lock_d;
  logic [2:0] lock_id_q, lock_id_d;

  // While a packet is open only its owner may be granted.
  always_comb begin
    eligible = req_valid;
    if (lock_q) begin
      eligible = req_valid & (NUM_REQ'(1) << lock_id_q);
    end
  end
`else
  assign eligible = req_valid;
`endif

  // First eligible requester at or after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_q) + k) % NUM_REQ;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = 3'(cand);
      end
    end
  end

  assign req_ready = (ser_idle && win_found && !rst) ? (NUM_REQ'(1) << win_id) : '0;
  assign accept    = |(req_valid & req_ready);
  assign win_data  = req_data[8*win_id +: 8];
  assign next_ptr  = (win_id == 3'(NUM_REQ - 1)) ? 3'd0 : win_id + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      grant_id_q <= '0;
`ifdef UART_TX_PACKET_LOCK_EN
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
`endif
    end else begin
      rr_q       <= rr_d;
      grant_id_q <= grant_id_d;
`ifdef UART_TX_PACKET_LOCK_EN
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
`endif
    end
  end

  always_comb begin
    rr_d       = rr_q;
    grant_id_d = grant_id_q;
`ifdef UART_TX_PACKET_LOCK_EN
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
`endif
    if (accept) begin
      grant_id_d = win_id;
`ifdef UART_TX_PACKET_LOCK_EN
      // Rotation only moves on once the packet is complete.
      if (req_last[win_id]) begin
        lock_d = 1'b0;
        rr_d   = next_ptr;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = win_id;
      end
`else
      rr_d = next_ptr;
`endif
    end
  end

  assign grant_id = grant_id_q;

  uart_tx_serial #(
    .DELAY_FRAMES(DELAY_FRAMES)
  ) u_serial (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (accept),
    .data_i  (win_data),
    .idle_o  (ser_idle),
    .busy_o  (busy),
    .tx_o    (uart_tx)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
// Optional feature macro: UART_TX_PACKET_LOCK_EN (enables the packet lock test)
module tb_uart_tx_arbiter;

  localparam int D     = 4;
  localparam int N     = 2;
  localparam int FRAME = 10 * D;
`ifdef UART_TX_PACKET_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           uart_tx;
  logic           busy;
  logic [2:0]     grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DELAY_FRAMES(D), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef UART_TX_PACKET_LOCK_EN
    .req_last  (req_last),
`endif
    .req_ready (req_ready),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: arbitration rules only, no notion of RTL state.
  int m_ptr     = 0;
  bit m_locked  = 1'b0;
  int m_lock_id = 0;
  int t_prev    = 0;
  int t_now     = 0;

  function automatic int model_winner(input logic [N-1:0] v);
    if (m_locked) return v[m_lock_id] ? m_lock_id : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_accept(input int w);
    if (LOCK_EN && !req_last[w]) begin
      m_locked  = 1'b1;
      m_lock_id = w;
    end else begin
      m_locked = 1'b0;
      m_ptr    = (w + 1) % N;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '1;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    m_ptr     = 0;
    m_locked  = 1'b0;
    m_lock_id = 0;
  endtask

  // Called at the first negedge after the accepting edge; returns at the
  // negedge where the line should be back in IDLE.
  task automatic check_frame(input string tag, input logic [7:0] exp, input int w, input int drop_at);
    int line_bad  = 0;
    int busy_cnt  = 0;
    int ready_bad = 0;
    logic [7:0] got = '0;
    for (int c = 0; c < FRAME; c++) begin
      int   b;
      logic e;
      b = c / D;
      e = (b == 0) ? 1'b0 : ((b <= 8) ? exp[b-1] : 1'b1);
      if (uart_tx !== e) line_bad++;
      if (busy === 1'b1) busy_cnt++;
      if (req_ready !== '0) ready_bad++;
      if (b >= 1 && b <= 8 && (c % D) == D / 2) got[b-1] = uart_tx;
      if (c == drop_at) req_valid = '0;
      @(negedge clk);
    end
    check_eq({tag, "_byte"}, 32'(got), 32'(exp));
    check_eq({tag, "_line"}, line_bad, 0);
    check_eq({tag, "_busy"}, busy_cnt, FRAME);
    check_eq({tag, "_rdy_mid"}, ready_bad, 0);
    check_eq({tag, "_gid"}, 32'(grant_id), w);
    check_eq({tag, "_end"}, {busy, uart_tx}, 2'b01);
  endtask

  // Entered at an IDLE negedge with inputs already applied.
  task automatic arbitrate(input string tag, input int drop_at);
    int w;
    logic [7:0] d;
    #1;
    w = model_winner(req_valid);
    check_eq({tag, "_rdy"}, 32'(req_ready), (w < 0) ? 0 : (1 << w));
    if (w < 0) begin
      @(negedge clk);
      return;
    end
    d = req_data[8*w +: 8];
    model_accept(w);
    @(negedge clk);
    t_prev = t_now;
    t_now  = cyc;
    check_frame(tag, d, w, drop_at);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;

    // Idle after reset.
    do_reset();
    check_eq("rst_gid", 32'(grant_id), 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx !== 1'b1 || req_ready !== '0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check_eq("idle_quiet", bad, 0);

    // Single byte from requester 0.
    req_data  = 16'h0055;
    req_valid = 2'b01;
    arbitrate("single", 0);
    #1 check_eq("single_after_rdy", 32'(req_ready), 0);
    @(negedge clk);

    // Both requesters holding valid: strict alternation, 41-cycle spacing.
    do_reset();
    req_data  = {8'h3C, 8'hA5};
    req_valid = 2'b11;
    arbitrate("alt0", -1);
    arbitrate("alt1", -1);
    check_eq("alt_spacing1", t_now - t_prev, 41);
    arbitrate("alt2", -1);
    check_eq("alt_spacing2", t_now - t_prev, 41);
    req_valid = '0;

    // Reset mid-frame restores priority to requester 0.
    do_reset();
    req_data  = {8'h3C, 8'h5A};
    req_valid = 2'b01;
    #1 check_eq("mid_rdy", 32'(req_ready), 32'h1);
    model_accept(0);
    @(negedge clk);
    req_valid = '0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_line", {busy, uart_tx}, 2'b01);
    check_eq("mid_rst_rdy", 32'(req_ready), 0);
    rst       = 1'b0;
    m_ptr     = 0;
    m_locked  = 1'b0;
    req_valid = 2'b11;
    #1 check_eq("mid_rst_rr", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    model_accept(0);
    t_now = cyc;
    check_frame("mid_after", 8'h5A, 0, -1);

    // Requester 1 raises valid mid-frame and drops it before IDLE.
    req_data  = {8'hEE, 8'h81};
    req_valid = 2'b01;
    #1;
    model_accept(0);
    @(negedge clk);
    req_valid = 2'b10;
    check_frame("drop", 8'h81, 0, 20);
    #1 check_eq("drop_rdy", 32'(req_ready), 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("drop_quiet", bad, 0);

`ifdef UART_TX_PACKET_LOCK_EN
    // Packet lock: requester 0 keeps the line for three bytes.
    do_reset();
    req_valid = 2'b11;
    req_last  = 2'b00;
    req_data  = {8'h3C, 8'h11};
    arbitrate("lk1", -1);
    #1 check_eq("lk_locked_rdy", 32'(req_ready), 32'h1);
    req_data  = {8'h3C, 8'h22};
    arbitrate("lk2", -1);
    req_data  = {8'h3C, 8'h33};
    req_last  = 2'b01;
    arbitrate("lk3", -1);
    req_last  = 2'b11;
    #1 check_eq("lk_release_rdy", 32'(req_ready), 32'h2);
    arbitrate("lk4", -1);
    req_valid = '0;
    @(negedge clk);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      req_valid = N'($urandom_range(0, 3));
      req_data  = 16'($urandom);
      req_last  = LOCK_EN ? N'($urandom_range(0, 3)) : '1;
      arbitrate("rnd", -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit line between NUM_REQ byte-producing requesters using round-robin arbitration.
- Accepts one byte per grant over a valid/ready handshake.
- Serializes each accepted byte as 8N1 (start bit, 8 data bits LSB first, one stop bit) at DELAY_FRAMES clocks per bit.
- Sits between on-chip producers (echo path, status reporter, debug dump) and the board's uart_tx pin; it is the transmit-side counterpart of the existing receiver.

Parameters:
- DELAY_FRAMES, 234, clocks per bit (27 MHz / 115200 baud); must be >= 2.
- NUM_REQ, 2, number of requesters; must be >= 2 and <= 8.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  NUM_REQ  requester i has a byte on its data slice.
- req_data  input  8*NUM_REQ  byte of requester i on bits [8*i+7:8*i].
- req_ready  output  NUM_REQ  one-hot grant; a byte transfers on a clock edge where req_valid[i] and req_ready[i] are both 1.
- uart_tx  output  1  serial line, idles high.
- busy  output  1  high while a frame is in progress (START, DATA or STOP).
- grant_id  output  3  index of the most recently granted requester.

Behaviour:
- Reset values: uart_tx=1, req_ready=0, busy=0, grant_id=0, state=IDLE, bit counter=0, baud counter=0, RR pointer=0 (requester 0 has highest priority after reset).
- On reset asserted mid-frame, the frame aborts; uart_tx is 1 from the next edge.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - req_ready is combinational: one-hot winner of req_valid, searched from the RR pointer upward with wrap-around; all zero if no valid.
  - On a transfer edge: latch the byte into the shift register, grant_id <= winner, RR pointer <= winner+1 mod NUM_REQ, state <= START, baud counter <= 0.
- START: uart_tx=0 for exactly DELAY_FRAMES cycles, then go to DATA.
- DATA:
  - uart_tx = shift register bit 0; each bit holds for DELAY_FRAMES cycles, then the register shifts right.
  - A 3-bit bit counter moves to STOP after bit 7.
- STOP: uart_tx=1 for DELAY_FRAMES cycles, then go to IDLE.
- req_ready is 0 in every state except IDLE, so producers must hold req_valid and req_data stable until ready.
- Frame length is 10*DELAY_FRAMES cycles. Minimum start-to-start spacing for back-to-back frames is 10*DELAY_FRAMES+1 cycles, because IDLE always lasts 1 cycle.
- A requester whose valid drops before a grant is not served; no byte is latched.
- Simultaneous valids are resolved by the RR pointer only. No requester waits more than NUM_REQ-1 frames while it continuously holds valid.
- Baud counter width is $clog2(DELAY_FRAMES); the counter wraps to 0 on reaching DELAY_FRAMES-1.
- uart_tx is registered (glitch-free).
- busy=1 from the cycle after acceptance until the last STOP cycle inclusive.

Optional Feature:
- Macro UART_TX_PACKET_LOCK_EN.
- When defined:
  - Adds input req_last [NUM_REQ].
  - After a grant, arbitration locks to that requester until a byte with req_last=1 has been accepted from it. In IDLE, only the locked requester can receive req_ready.
  - The RR pointer advances only on acceptance of a last byte.
  - Reset clears the lock.
- When undefined: port absent; arbitration is per byte as described above.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants (IDLE=0, START=1, DATA=2, STOP=3);
  - DEFAULT_DELAY_FRAMES=234;
  - frame bit count 8.
- One sub-module uart_tx_serial (byte in with start pulse, busy out, uart_tx out, DELAY_FRAMES parameter) owns the START/DATA/STOP timing.
- The top level keeps the round-robin pointer, grant logic and the optional lock.

Test Plan (DELAY_FRAMES=4, NUM_REQ=2):
- Idle after reset, no valids -> uart_tx=1, req_ready=00, busy=0 for 100 cycles.
- Req0 valid with 0x55 -> req_ready=01 in 1 cycle; uart_tx shows 0 then 1,0,1,0,1,0,1,0 then 1, each bit 4 cycles; busy high for 40 cycles; grant_id=0.
- Both valid continuously (0xA5 on req0, 0x3C on req1) -> frames alternate 0xA5, 0x3C, 0xA5; frame start edges 41 cycles apart.
- rst pulsed at cycle 15 of a frame -> uart_tx=1 and busy=0 next cycle; next grant goes to req0 even if req1 was next in rotation.
- Req1 valid then dropped before IDLE -> no grant to req1, no frame sent.
- With UART_TX_PACKET_LOCK_EN: req0 sends 3 bytes (last on the third) while req1 is valid -> req1 granted only after req0's third byte is accepted.
